// File: rtl/booth_sched_pkg.sv
// Shared constants for the booth multiplier scheduler: FSM state codes and ID width helper.
package booth_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, cyclically.
module rr_arbiter
  import booth_sched_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Scan ptr+1 .. ptr+N so the last-served requester has lowest priority.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (en && !found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mult.sv
// Round-robin scheduler sharing one external booth_mult between N requesters.
module booth_mult_sched
  import booth_sched_pkg::*;
#(
  parameter  int unsigned N        = 4,
  parameter  int unsigned W        = 8,
  parameter  int unsigned MULT_LAT = 8,
  localparam int unsigned IW       = id_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_a,
  input  logic [N*W-1:0]  req_b,
  output logic [N-1:0]    req_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IW-1:0]   rsp_id,
  output logic [2*W-1:0]  rsp_y,
  output logic [W-1:0]    mult_a,
  output logic [W-1:0]    mult_b,
  output logic            mult_load,
  input  logic [2*W-1:0]  mult_y
);

  localparam int unsigned CW = $clog2(MULT_LAT + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id_q;
  logic [N-1:0]  grant;
  logic [IW-1:0] gidx;
  logic          arb_en;

  // Gated by rst so no accept strobe leaks out while reset is held.
  assign arb_en    = (state == ST_IDLE) && !rst;
  assign req_ready = grant;

  rr_arbiter #(.N(N)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (arb_en),
    .grant (grant),
    .idx   (gidx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mult_load <= 1'b0;
      rsp_valid <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      cnt       <= '0;
      id_q      <= '0;
      ptr       <= IW'(N - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            mult_a    <= req_a[gidx*W +: W];
            mult_b    <= req_b[gidx*W +: W];
            id_q      <= gidx;
            mult_load <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          mult_load <= 1'b0;
          cnt       <= CW'(MULT_LAT - 1);
          state     <= ST_BUSY;
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            rsp_y     <= mult_y;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= id_q;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_sched.sv
// Directed bench for booth_mult_sched with a fixed-latency multiplier model on mult_y.
module tb_booth_mult_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [2*W-1:0]  rsp_y;
  logic [W-1:0]    mult_a;
  logic [W-1:0]    mult_b;
  logic            mult_load;
  logic [2*W-1:0]  mult_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mult_sched #(.N(N), .W(W), .MULT_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_load (mult_load),
    .mult_y    (mult_y)
  );

  // Multiplier model: product valid only LAT cycles after the load cycle ends.
  logic signed [2*W-1:0] prod;
  int                    lat_cnt;
  logic                  have;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      have    <= 1'b0;
      lat_cnt <= 0;
      prod    <= '0;
    end else if (mult_load) begin
      have    <= 1'b1;
      lat_cnt <= LAT - 1;
      prod    <= $signed(mult_a) * $signed(mult_b);
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
    end
  end

  assign mult_y = (have && lat_cnt == 0) ? prod : 16'hA5A5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id]    = 1'b1;
  endtask

  task automatic serve(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] y, input int hold);
    int   n;
    int   lat;
    int   loads;
    int   strays;
    logic bad;
    rsp_ready = (hold == 0);
    #1;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("grant", 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid[id] = 1'b0;
    #1;
    check("load", 32'(mult_load), 32'd1);
    check("mult_a", 32'(mult_a), 32'(a));
    check("mult_b", 32'(mult_b), 32'(b));
    lat    = 1;
    loads  = int'(mult_load);
    strays = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk); #1; lat++;
      if (mult_load) loads++;
      if (req_ready != '0) strays++;
    end
    check("latency", 32'(lat), 32'(2 + LAT));
    check("load_pulses", 32'(loads), 32'd1);
    check("stray_ready", 32'(strays), 32'd0);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_y", 32'(rsp_y), 32'(y));
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      if (!rsp_valid || rsp_y !== y || 32'(rsp_id) !== 32'(id) || req_ready != '0 || mult_load)
        bad = 1'b1;
    end
    if (hold > 0) check("hold_stable", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {req_ready, rsp_valid, mult_load, rsp_id, 24'd0} | 32'(rsp_y) | 32'(mult_a) | 32'(mult_b), 32'd0);
  endtask

  initial begin
    int idle_bad;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check_all_zero("reset_state");
    rst = 1'b0;

    // Idle hold: nothing requested for 20 cycles.
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (req_ready != '0 || mult_load || rsp_valid) idle_bad++;
    end
    check("idle_hold", 32'(idle_bad), 32'd0);

    // Single request and signed operands.
    @(negedge clk);
    set_req(0, 8'd20, 8'd30);
    serve(0, 8'd20, 8'd30, 16'h0258, 0);
    set_req(2, 8'hFB, 8'd7);
    serve(2, 8'hFB, 8'd7, 16'hFFDD, 0);

    // Round robin from a fresh pointer.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_req(0, 8'd1, 8'd2);
    set_req(1, 8'd3, 8'd4);
    set_req(2, 8'd5, 8'd6);
    set_req(3, 8'd7, 8'd8);
    serve(0, 8'd1, 8'd2, 16'd2, 0);
    serve(1, 8'd3, 8'd4, 16'd12, 0);
    serve(2, 8'd5, 8'd6, 16'd30, 0);
    serve(3, 8'd7, 8'd8, 16'd56, 0);
    set_req(0, 8'd9, 8'd10);
    set_req(3, 8'd11, 8'd2);
    serve(0, 8'd9, 8'd10, 16'd90, 0);
    serve(3, 8'd11, 8'd2, 16'd22, 0);

    // Backpressure, then the next pending grant follows.
    set_req(1, 8'd16, 8'd16);
    set_req(2, 8'd2, 8'd3);
    serve(1, 8'd16, 8'd16, 16'h0100, 5);
    serve(2, 8'd2, 8'd3, 16'd6, 0);

    // Reset during BUSY with counter at 3.
    set_req(3, 8'd4, 8'd5);
    #1;
    check("abort_grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid[3] = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) idle_bad++;
    end
    check("no_rsp_after_abort", 32'(idle_bad), 32'd0);
    set_req(1, 8'h80, 8'd2);
    serve(1, 8'h80, 8'd2, 16'hFF00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
